mem_spi_xfer_engine: RTL and testbench

SPI-side transfer engine that executes a burst of byte transfers to the external memory and reports each completed transfer upstream. It sits between the transaction FSM/data path and the SPI pins. It emits the per-transfer completion pulses and the burst-complete pulse that the status poller counts against its total. SPI mode 0, MSB first, single chip select.

---
 rtl/mem_spi_xfer_engine.sv | 166 ++++++++++++++++
 tb/tb_mem_spi_xfer_engine.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_spi_xfer_engine.sv
// SPI mode-0 burst transfer engine: shifts a counted burst of bytes MSB first
// under one chip select and reports per-byte and end-of-burst completion.
module mem_spi_xfer_engine #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_start,
  input  logic [7:0] in_total_transfers,
  input  logic [7:0] in_tx_data,
  input  logic       in_tx_valid,
  output logic       out_tx_ready,
  output logic [7:0] out_rx_data,
  output logic       out_rx_valid,
  output logic       out_transfer_done,
  output logic [7:0] out_transfers_completed,
  output logic       out_busy,
  output logic       out_all_done,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    BYTE_END,
    CS_HOLD,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] total_q, total_d;
  logic [7:0] completed_q, completed_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic       phase_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      total_q     <= 8'd0;
      completed_q <= 8'd0;
      tx_shift_q  <= 8'd0;
      rx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      completed_q <= completed_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    completed_d = completed_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    phase_end   = (div_q == DivLast);

    case (state_q)
      IDLE: begin
        if (in_start) begin
          if (in_total_transfers == 8'd0) begin
            state_d = DONE;
          end else begin
            total_d     = in_total_transfers;
            completed_d = 8'd0;
            cs_n_d      = 1'b0;
            state_d     = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_tx_valid) begin
          tx_shift_d = in_tx_data;
          bit_d      = 3'd0;
          div_d      = 8'd0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Rising edge samples MISO; falling edge advances MOSI and the bit count.
        if (phase_end) begin
          div_d  = 8'd0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_shift_d = {rx_shift_q[6:0], spi_miso};
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            bit_d      = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rx_data_d = rx_shift_q;
              if (completed_q != total_q) begin
                completed_d = completed_q + 8'd1;
              end
              state_d = BYTE_END;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      BYTE_END: begin
        div_d   = 8'd0;
        state_d = (completed_q == total_q) ? CS_HOLD : LOAD;
      end
      CS_HOLD: begin
        if (div_q == DivLast) begin
          state_d = DONE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // CS releases for the final hold cycle so it is already high the cycle before DONE.
    if (state_d == CS_HOLD && div_d == DivLast) begin
      cs_n_d = 1'b1;
    end
  end

  assign out_tx_ready            = (state_q == LOAD);
  assign out_rx_valid            = (state_q == BYTE_END);
  assign out_transfer_done       = (state_q == BYTE_END);
  assign out_all_done            = (state_q == DONE);
  assign out_busy                = (state_q != IDLE);
  assign out_rx_data             = rx_data_q;
  assign out_transfers_completed = completed_q;
  assign spi_sclk                = sclk_q;
  assign spi_cs_n                = cs_n_q;
  assign spi_mosi                = tx_shift_q[7];

endmodule

// File: tb/tb_mem_spi_xfer_engine.sv
// Self-checking bench for mem_spi_xfer_engine: a CLK_DIV=2 instance driven from a
// vector table with a scoreboard, plus a CLK_DIV=1 instance for the stress case.
module tb_mem_spi_xfer_engine;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] miso;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // CLK_DIV=2 instance
  logic       start = 1'b0, txValid = 1'b0, miso = 1'b0;
  logic [7:0] total = 8'd0, txData = 8'd0;
  logic       txReady, rxValid, xferDone, busy, allDone, sclk, csN, mosi;
  logic [7:0] rxData, completed;

  // CLK_DIV=1 instance
  logic       start1 = 1'b0, txValid1 = 1'b0, miso1 = 1'b0;
  logic [7:0] total1 = 8'd0, txData1 = 8'd0;
  logic       txReady1, rxValid1, xferDone1, busy1, allDone1, sclk1, csN1, mosi1;
  logic [7:0] rxData1, completed1;

  mem_spi_xfer_engine #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .in_start(start), .in_total_transfers(total),
    .in_tx_data(txData), .in_tx_valid(txValid), .out_tx_ready(txReady),
    .out_rx_data(rxData), .out_rx_valid(rxValid), .out_transfer_done(xferDone),
    .out_transfers_completed(completed), .out_busy(busy), .out_all_done(allDone),
    .spi_sclk(sclk), .spi_cs_n(csN), .spi_mosi(mosi), .spi_miso(miso)
  );

  mem_spi_xfer_engine #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .in_start(start1), .in_total_transfers(total1),
    .in_tx_data(txData1), .in_tx_valid(txValid1), .out_tx_ready(txReady1),
    .out_rx_data(rxData1), .out_rx_valid(rxValid1), .out_transfer_done(xferDone1),
    .out_transfers_completed(completed1), .out_busy(busy1), .out_all_done(allDone1),
    .spi_sclk(sclk1), .spi_cs_n(csN1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  vec_t       vecs[8];
  logic [7:0] expRx[$], expTx[$], expCnt[$], misoQ[$], misoQ1[$];
  int         hsCyc[$], doneCyc[$], allDoneCyc[$];
  int         csRiseCyc = -1, csRiseCnt = 0;
  bit         csLowSeen = 1'b0, readySeen = 1'b0;
  int         rise1Cyc[$], done1Cyc[$], hs1Cyc[$];
  logic [7:0] rx1[$], tx1[$];
  int         allDone1Cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Monitor and MISO slave model for the CLK_DIV=2 instance
  initial begin
    logic       prevSclk = 1'b0, prevCs = 1'b1;
    logic [7:0] mosiShift = 8'd0, misoCur = 8'd0;
    int         misoIdx = 7;
    forever begin
      @(negedge clk);
      if (sclk && !prevSclk) mosiShift = {mosiShift[6:0], mosi};
      if (!csN && prevCs) begin
        misoCur = (misoQ.size() > 0) ? misoQ.pop_front() : 8'h00;
        misoIdx = 7;
        miso    = misoCur[7];
      end else if (!sclk && prevSclk) begin
        if (misoIdx == 0) begin
          misoCur = (misoQ.size() > 0) ? misoQ.pop_front() : 8'h00;
          misoIdx = 7;
        end else begin
          misoIdx--;
        end
        miso = misoCur[misoIdx];
      end
      if (csN && !prevCs) begin
        csRiseCyc = cyc;
        csRiseCnt++;
      end
      if (!csN) csLowSeen = 1'b1;
      if (txReady) readySeen = 1'b1;
      if (xferDone) begin
        doneCyc.push_back(cyc);
        checkOutput("rx_valid_with_done", rxValid, 1);
        if (expRx.size() == 0) begin
          checkOutput("unexpected_done_pulse", 1, 0);
        end else begin
          checkOutput("rx_data", rxData, expRx.pop_front());
          checkOutput("mosi_byte", mosiShift, expTx.pop_front());
          checkOutput("transfers_completed", completed, expCnt.pop_front());
        end
      end
      if (allDone) allDoneCyc.push_back(cyc);
      prevSclk = sclk;
      prevCs   = csN;
    end
  end

  // Monitor and MISO slave model for the CLK_DIV=1 instance
  initial begin
    logic       prevSclk = 1'b0, prevCs = 1'b1;
    logic [7:0] mosiShift = 8'd0, misoCur = 8'd0;
    int         misoIdx = 7;
    forever begin
      @(negedge clk);
      if (sclk1 && !prevSclk) begin
        rise1Cyc.push_back(cyc);
        mosiShift = {mosiShift[6:0], mosi1};
      end
      if (!csN1 && prevCs) begin
        misoCur = (misoQ1.size() > 0) ? misoQ1.pop_front() : 8'h00;
        misoIdx = 7;
        miso1   = misoCur[7];
      end else if (!sclk1 && prevSclk) begin
        if (misoIdx == 0) begin
          misoCur = (misoQ1.size() > 0) ? misoQ1.pop_front() : 8'h00;
          misoIdx = 7;
        end else begin
          misoIdx--;
        end
        miso1 = misoCur[misoIdx];
      end
      if (xferDone1) begin
        done1Cyc.push_back(cyc);
        rx1.push_back(rxData1);
        tx1.push_back(mosiShift);
      end
      if (allDone1) allDone1Cnt++;
      prevSclk = sclk1;
      prevCs   = csN1;
    end
  end

  task automatic waitReady(input string name);
    int k = 0;
    while (!txReady && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, txReady, 1);
  endtask

  task automatic waitAllDone(input string name, input int prev);
    int k = 0;
    while (allDoneCyc.size() <= prev && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    checkOutput(name, allDoneCyc.size() > prev, 1);
  endtask

  // Runs one burst from the vector table; optional stall before the second byte.
  task automatic applyStimulus(input int first, input int n, input bit stall);
    bit sclkBad = 1'b0, csBad = 1'b0, readyBad = 1'b0;
    for (int i = 0; i < n; i++) misoQ.push_back(vecs[first+i].miso);
    start = 1'b1;
    total = 8'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (stall && i == 1) begin
        txValid = 1'b0;
        waitReady("stall_ready_timeout");
        for (int s = 0; s < 20; s++) begin
          if (s == 5) begin
            start = 1'b1;
            total = 8'd9;
          end else begin
            start = 1'b0;
          end
          @(negedge clk);
          if (sclk !== 1'b0) sclkBad = 1'b1;
          if (csN !== 1'b0) csBad = 1'b1;
          if (txReady !== 1'b1) readyBad = 1'b1;
        end
        start = 1'b0;
        checkOutput("stall_sclk_low", sclkBad, 0);
        checkOutput("stall_cs_low", csBad, 0);
        checkOutput("stall_ready_high", readyBad, 0);
      end
      txData  = vecs[first+i].tx;
      txValid = 1'b1;
      waitReady("handshake_timeout");
      expRx.push_back(vecs[first+i].miso);
      expTx.push_back(vecs[first+i].tx);
      expCnt.push_back(8'(i + 1));
      @(negedge clk);
      hsCyc.push_back(cyc);
    end
    txValid = 1'b0;
  endtask

  task automatic clearRecords();
    hsCyc.delete();
    doneCyc.delete();
    allDoneCyc.delete();
    csRiseCyc = -1;
    csRiseCnt = 0;
  endtask

  initial begin
    int nDone;
    logic [7:0] t1[2], m1[2];
    int k;

    vecs[0] = '{tx: 8'hA5, miso: 8'h3C};
    vecs[1] = '{tx: 8'h01, miso: 8'hC3};
    vecs[2] = '{tx: 8'h80, miso: 8'h5A};
    vecs[3] = '{tx: 8'hFF, miso: 8'h0F};
    vecs[4] = '{tx: 8'h96, miso: 8'h69};
    vecs[5] = '{tx: 8'h3E, miso: 8'hE7};
    vecs[6] = '{tx: 8'h12, miso: 8'h34};
    vecs[7] = '{tx: 8'h56, miso: 8'h78};

    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", csN, 1);
    checkOutput("reset_sclk", sclk, 0);
    checkOutput("reset_mosi", mosi, 0);
    checkOutput("reset_tx_ready", txReady, 0);
    checkOutput("reset_rx_valid", rxValid, 0);
    checkOutput("reset_xfer_done", xferDone, 0);
    checkOutput("reset_all_done", allDone, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rx_data", rxData, 0);
    checkOutput("reset_completed", completed, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single byte");
    clearRecords();
    applyStimulus(0, 1, 1'b0);
    waitAllDone("single_all_done_seen", 0);
    repeat (3) @(negedge clk);
    checkOutput("single_done_count", doneCyc.size(), 1);
    if (doneCyc.size() > 0 && hsCyc.size() > 0 && allDoneCyc.size() > 0) begin
      checkOutput("single_done_latency", doneCyc[0] - hsCyc[0], 32);
      checkOutput("single_all_done_delay", allDoneCyc[0] - doneCyc[0], 3);
      checkOutput("single_cs_rise_before_done", allDoneCyc[0] - csRiseCyc, 1);
    end
    checkOutput("single_rx_held", rxData, 8'h3C);
    checkOutput("single_idle_busy", busy, 0);

    $display("[TB] burst of three");
    clearRecords();
    applyStimulus(1, 3, 1'b0);
    waitAllDone("burst_all_done_seen", 0);
    repeat (10) @(negedge clk);
    checkOutput("burst_done_count", doneCyc.size(), 3);
    if (doneCyc.size() == 3) begin
      checkOutput("burst_spacing_1", doneCyc[1] - doneCyc[0], 34);
      checkOutput("burst_spacing_2", doneCyc[2] - doneCyc[1], 34);
    end
    checkOutput("burst_all_done_once", allDoneCyc.size(), 1);
    checkOutput("burst_cs_single_rise", csRiseCnt, 1);
    if (allDoneCyc.size() > 0)
      checkOutput("burst_cs_rise_before_done", allDoneCyc[0] - csRiseCyc, 1);

    $display("[TB] zero length");
    clearRecords();
    csLowSeen = 1'b0;
    readySeen = 1'b0;
    start = 1'b1;
    total = 8'd0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero_all_done", allDone, 1);
    checkOutput("zero_busy_in_done", busy, 1);
    @(negedge clk);
    checkOutput("zero_all_done_one_cycle", allDone, 0);
    checkOutput("zero_busy_after", busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("zero_cs_never_low", csLowSeen, 0);
    checkOutput("zero_ready_never_high", readySeen, 0);

    $display("[TB] underrun with ignored start");
    clearRecords();
    applyStimulus(4, 2, 1'b1);
    waitAllDone("underrun_all_done_seen", 0);
    repeat (50) @(negedge clk);
    checkOutput("underrun_done_count", doneCyc.size(), 2);
    if (doneCyc.size() == 2)
      checkOutput("underrun_gap_includes_stall", (doneCyc[1] - doneCyc[0]) >= 54, 1);
    checkOutput("underrun_all_done_once", allDoneCyc.size(), 1);
    checkOutput("underrun_completed", completed, 2);
    checkOutput("underrun_idle_busy", busy, 0);

    $display("[TB] reset mid-shift");
    clearRecords();
    misoQ.push_back(vecs[6].miso);
    misoQ.push_back(vecs[7].miso);
    start = 1'b1;
    total = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 6; i < 8; i++) begin
      txData  = vecs[i].tx;
      txValid = 1'b1;
      waitReady("rst_handshake_timeout");
      expRx.push_back(vecs[i].miso);
      expTx.push_back(vecs[i].tx);
      expCnt.push_back(8'(i - 5));
      @(negedge clk);
    end
    txValid = 1'b0;
    repeat (10) @(negedge clk);
    nDone = doneCyc.size();
    checkOutput("rst_first_byte_done", nDone, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_cs_n", csN, 1);
    checkOutput("rst_sclk", sclk, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_completed", completed, 0);
    checkOutput("rst_rx_data", rxData, 0);
    checkOutput("rst_tx_ready", txReady, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expRx.delete();
    expTx.delete();
    expCnt.delete();
    misoQ.delete();
    repeat (40) @(negedge clk);
    checkOutput("rst_no_done_pulse", doneCyc.size(), nDone);
    checkOutput("rst_stays_idle", csN, 1);

    $display("[TB] CLK_DIV=1 stress");
    for (int i = 0; i < 2; i++) begin
      t1[i] = 8'($urandom_range(0, 255));
      m1[i] = 8'($urandom_range(0, 255));
      misoQ1.push_back(m1[i]);
    end
    start1 = 1'b1;
    total1 = 8'd2;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      txData1  = t1[i];
      txValid1 = 1'b1;
      k = 0;
      while (!txReady1 && k < 100) begin
        @(negedge clk);
        k++;
      end
      checkOutput("div1_handshake_timeout", txReady1, 1);
      @(negedge clk);
      hs1Cyc.push_back(cyc);
    end
    txValid1 = 1'b0;
    k = 0;
    while (allDone1Cnt == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    checkOutput("div1_all_done_once", allDone1Cnt, 1);
    checkOutput("div1_done_count", done1Cyc.size(), 2);
    checkOutput("div1_rise_count", rise1Cyc.size(), 16);
    if (done1Cyc.size() == 2) begin
      checkOutput("div1_first_latency", done1Cyc[0] - hs1Cyc[0], 16);
      checkOutput("div1_byte_spacing", done1Cyc[1] - done1Cyc[0], 18);
      for (int i = 0; i < 2; i++) begin
        checkOutput("div1_rx_data", rx1[i], m1[i]);
        checkOutput("div1_mosi_byte", tx1[i], t1[i]);
      end
    end
    if (rise1Cyc.size() == 16) begin
      for (int i = 1; i < 16; i++) begin
        if (i % 8 != 0) checkOutput("div1_sclk_period", rise1Cyc[i] - rise1Cyc[i-1], 2);
      end
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
